// File: rtl/valid_array_pkg.sv
// Shared definitions for the valid-bit array: controller state type and its encoding.
package valid_array_pkg;

    localparam int STATE_WIDTH = 2;

    localparam logic [STATE_WIDTH-1:0] ENC_INIT  = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ENC_IDLE  = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ENC_FLUSH = 2'd2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_INIT  = ENC_INIT,
        ST_IDLE  = ENC_IDLE,
        ST_FLUSH = ENC_FLUSH
    } state_e;

    // Both INIT and FLUSH own the array and clear one set per cycle.
    function automatic logic is_sweeping(input state_e state);
        return state != ST_IDLE;
    endfunction

endpackage

// File: rtl/single_port_lutram.sv
// One way's column of valid bits: synchronous write, asynchronous read, no reset on contents.
module single_port_lutram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wdata_i,
    output logic              rdata_o
);

    logic mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/valid_array_flush_ctrl.sv
// Per-set/per-way valid-bit store with registered read, masked writes, first-invalid hint
// and a sequential invalidate sweep that runs after reset and on flush request.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  INIT  | post-reset sweep: clear one set per cycle, accesses dropped
//  IDLE  | accepting reads/writes, flush_req_in starts a sweep
//  FLUSH | requested sweep: clear one set per cycle, accesses dropped
module valid_array_flush_ctrl #(
    parameter int NUMBER_SET            = 64,
    parameter int NUMBER_WAY            = 16,
    parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SET),
    parameter int WAY_PTR_WIDTH_IN_BITS = $clog2(NUMBER_WAY)
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             access_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0] access_set_addr_in,
    input  logic                             write_en_in,
    input  logic [NUMBER_WAY-1:0]            write_way_select_in,
    input  logic                             write_value_in,
    input  logic                             flush_req_in,
    output logic                             ready_out,
    output logic                             read_valid_out,
    output logic [NUMBER_WAY-1:0]            read_set_valid_out,
    output logic                             read_all_valid_out,
    output logic [WAY_PTR_WIDTH_IN_BITS-1:0] read_first_invalid_way_out,
    output logic                             flush_done_out
);

    import valid_array_pkg::*;

    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SET - 1);

    state_e                           state_q, state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] ptr_q, ptr_d;
    logic                             done_q, done_d;
    logic                             rd_valid_q, rd_valid_d;
    logic [NUMBER_WAY-1:0]            rd_set_q, rd_set_d;

    logic                             sweeping;
    logic                             acc_wr;
    logic                             acc_rd;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] mem_addr;
    logic                             mem_wdata;
    logic [NUMBER_WAY-1:0]            mem_rdata;
    logic [WAY_PTR_WIDTH_IN_BITS-1:0] first_inv;

    assign ready_out = (state_q == ST_IDLE);
    assign sweeping  = is_sweeping(state_q);
    assign acc_wr    = ready_out & access_en_in & write_en_in;
    assign acc_rd    = ready_out & access_en_in & ~write_en_in;
    assign mem_addr  = sweeping ? ptr_q : access_set_addr_in;
    assign mem_wdata = sweeping ? 1'b0 : write_value_in;

    for (genvar g = 0; g < NUMBER_WAY; g++) begin : g_way
        single_port_lutram #(
            .DEPTH  (NUMBER_SET),
            .ADDR_W (SET_PTR_WIDTH_IN_BITS)
        ) u_way (
            .clk_i   (clk_in),
            .we_i    ((acc_wr & write_way_select_in[g]) | sweeping),
            .addr_i  (mem_addr),
            .wdata_i (mem_wdata),
            .rdata_o (mem_rdata[g])
        );
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_set_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_set_q   <= rd_set_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        done_d     = 1'b0;
        rd_valid_d = acc_rd;
        rd_set_d   = acc_rd ? mem_rdata : rd_set_q;
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                // Pointer wraps to 0 after the last set, ready for the next sweep.
                ptr_d = ptr_q + SET_PTR_WIDTH_IN_BITS'(1);
                if (ptr_q == LAST_SET) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (flush_req_in) begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Lowest invalid way wins; all-valid falls through to 0.
    always_comb begin
        first_inv = '0;
        for (int i = NUMBER_WAY - 1; i >= 0; i--) begin
            if (!rd_set_q[i]) begin
                first_inv = WAY_PTR_WIDTH_IN_BITS'(i);
            end
        end
    end

    assign read_valid_out             = rd_valid_q;
    assign read_set_valid_out         = rd_set_q;
    assign read_all_valid_out         = &rd_set_q;
    assign read_first_invalid_way_out = first_inv;
    assign flush_done_out             = done_q;

endmodule

// File: tb/tb_valid_array_flush_ctrl.sv
// Self-checking bench for valid_array_flush_ctrl: vector table, directed flush/reset sequences,
// randomized traffic against an array model, and a small 8-set/3-way build.
module tb_valid_array_flush_ctrl;

    localparam int NS = 64;
    localparam int NW = 16;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        access_en_in;
    logic [5:0]  access_set_addr_in;
    logic        write_en_in;
    logic [15:0] write_way_select_in;
    logic        write_value_in;
    logic        flush_req_in;
    logic        ready_out;
    logic        read_valid_out;
    logic [15:0] read_set_valid_out;
    logic        read_all_valid_out;
    logic [3:0]  read_first_invalid_way_out;
    logic        flush_done_out;

    logic        s_rst;
    logic        s_en;
    logic [2:0]  s_addr;
    logic        s_we;
    logic [2:0]  s_mask;
    logic        s_val;
    logic        s_flush;
    logic        s_ready;
    logic        s_rv;
    logic [2:0]  s_set;
    logic        s_all;
    logic [1:0]  s_first;
    logic        s_done;

    always #5 clk_in = ~clk_in;

    valid_array_flush_ctrl dut (
        .clk_in                     (clk_in),
        .reset_in                   (reset_in),
        .access_en_in               (access_en_in),
        .access_set_addr_in         (access_set_addr_in),
        .write_en_in                (write_en_in),
        .write_way_select_in        (write_way_select_in),
        .write_value_in             (write_value_in),
        .flush_req_in               (flush_req_in),
        .ready_out                  (ready_out),
        .read_valid_out             (read_valid_out),
        .read_set_valid_out         (read_set_valid_out),
        .read_all_valid_out         (read_all_valid_out),
        .read_first_invalid_way_out (read_first_invalid_way_out),
        .flush_done_out             (flush_done_out)
    );

    valid_array_flush_ctrl #(.NUMBER_SET(8), .NUMBER_WAY(3)) dut_small (
        .clk_in                     (clk_in),
        .reset_in                   (s_rst),
        .access_en_in               (s_en),
        .access_set_addr_in         (s_addr),
        .write_en_in                (s_we),
        .write_way_select_in        (s_mask),
        .write_value_in             (s_val),
        .flush_req_in               (s_flush),
        .ready_out                  (s_ready),
        .read_valid_out             (s_rv),
        .read_set_valid_out         (s_set),
        .read_all_valid_out         (s_all),
        .read_first_invalid_way_out (s_first),
        .flush_done_out             (s_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: whole-array view, sweep tracked as a count of remaining busy cycles.
    logic [15:0] m_mem [NS];
    int          m_busy;
    logic        m_rv;
    logic        m_done;
    logic [15:0] m_set;

    typedef struct {
        logic        en;
        logic [5:0]  addr;
        logic        we;
        logic [15:0] mask;
        logic        val;
        logic        exp_rv;
        logic [15:0] exp_set;
        logic [3:0]  exp_first;
        logic        exp_all;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic en, input logic [5:0] addr, input logic we,
                                input logic [15:0] mask, input logic val, input logic exp_rv,
                                input logic [15:0] exp_set, input logic [3:0] exp_first,
                                input logic exp_all);
        vec_t v;
        v.en = en; v.addr = addr; v.we = we; v.mask = mask; v.val = val;
        v.exp_rv = exp_rv; v.exp_set = exp_set; v.exp_first = exp_first; v.exp_all = exp_all;
        return v;
    endfunction

    function automatic logic [3:0] ref_first(input logic [15:0] v);
        for (int i = 0; i < NW; i++) begin
            if (!v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = NS;
        m_rv   = 1'b0;
        m_done = 1'b0;
        m_set  = '0;
        for (int s = 0; s < NS; s++) m_mem[s] = '0;
    endtask

    task automatic model_step(input logic en, input logic [5:0] a, input logic we,
                              input logic [15:0] mk_, input logic v, input logic fl,
                              input logic rst);
        if (rst) begin
            model_reset();
        end else begin
            m_rv   = 1'b0;
            m_done = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1'b1;
                    for (int s = 0; s < NS; s++) m_mem[s] = '0;
                end
            end else begin
                if (en) begin
                    if (we) begin
                        m_mem[a] = v ? (m_mem[a] | mk_) : (m_mem[a] & ~mk_);
                    end else begin
                        m_rv  = 1'b1;
                        m_set = m_mem[a];
                    end
                end
                if (fl) m_busy = NS;
            end
        end
    endtask

    task automatic check_outputs();
        check("ready",         32'(ready_out),                  32'(m_busy == 0));
        check("read_valid",    32'(read_valid_out),             32'(m_rv));
        check("read_set",      32'(read_set_valid_out),         32'(m_set));
        check("all_valid",     32'(read_all_valid_out),         32'(&m_set));
        check("first_invalid", 32'(read_first_invalid_way_out), 32'(ref_first(m_set)));
        check("flush_done",    32'(flush_done_out),             32'(m_done));
    endtask

    task automatic cycle(input logic en, input logic [5:0] a, input logic we,
                         input logic [15:0] mk_, input logic v, input logic fl);
        access_en_in        = en;
        access_set_addr_in  = a;
        write_en_in         = we;
        write_way_select_in = mk_;
        write_value_in      = v;
        flush_req_in        = fl;
        @(posedge clk_in);
        model_step(en, a, we, mk_, v, fl, reset_in);
        #1;
        check_outputs();
    endtask

    task automatic run_init(input string nm);
        int n;
        int dones;
        n = 0;
        dones = 0;
        for (int k = 0; k < 200; k++) begin
            cycle(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0);
            n++;
            dones += int'(flush_done_out);
            if (ready_out) break;
        end
        check({nm, "_len"}, 32'(n), 32'd64);
        check({nm, "_done_pulses"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int low;
        int dones;
        int n;

        reset_in = 1'b1;
        access_en_in = 1'b0; access_set_addr_in = '0; write_en_in = 1'b0;
        write_way_select_in = '0; write_value_in = 1'b0; flush_req_in = 1'b0;
        s_rst = 1'b1; s_en = 1'b0; s_addr = '0; s_we = 1'b0; s_mask = '0; s_val = 1'b0; s_flush = 1'b0;

        vecs[0]  = mk(1'b1, 6'd5, 1'b1, 16'h00F0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0);
        vecs[1]  = mk(1'b1, 6'd5, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00F0, 4'd0, 1'b0);
        vecs[2]  = mk(1'b1, 6'd5, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h00F0, 4'd0, 1'b0);
        vecs[3]  = mk(1'b1, 6'd5, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h00F0, 4'd0, 1'b0);
        vecs[4]  = mk(1'b1, 6'd5, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFF7, 4'd3, 1'b0);
        vecs[5]  = mk(1'b1, 6'd5, 1'b1, 16'h0008, 1'b1, 1'b0, 16'hFFF7, 4'd3, 1'b0);
        vecs[6]  = mk(1'b1, 6'd5, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 4'd0, 1'b1);
        vecs[7]  = mk(1'b1, 6'd5, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b1);
        vecs[8]  = mk(1'b1, 6'd5, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 4'd0, 1'b1);
        vecs[9]  = mk(1'b1, 6'd6, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0);
        vecs[10] = mk(1'b1, 6'd6, 1'b1, 16'h8001, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0);
        vecs[11] = mk(1'b1, 6'd6, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h8001, 4'd1, 1'b0);
        vecs[12] = mk(1'b0, 6'd6, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h8001, 4'd1, 1'b0);

        repeat (3) @(posedge clk_in);
        #1;
        model_reset();
        check_outputs();

        reset_in = 1'b0;
        run_init("init");

        for (int s = 0; s < NS; s++) cycle(1'b1, 6'(s), 1'b0, 16'h0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].en, vecs[i].addr, vecs[i].we, vecs[i].mask, vecs[i].val, 1'b0);
            check($sformatf("vec%0d_rv", i),    32'(read_valid_out),             32'(vecs[i].exp_rv));
            check($sformatf("vec%0d_set", i),   32'(read_set_valid_out),         32'(vecs[i].exp_set));
            check($sformatf("vec%0d_first", i), 32'(read_first_invalid_way_out), 32'(vecs[i].exp_first));
            check($sformatf("vec%0d_all", i),   32'(read_all_valid_out),         32'(vecs[i].exp_all));
        end

        // Flush with a concurrent read: old data returned, then a full sweep with dropped traffic.
        cycle(1'b1, 6'd0,  1'b1, 16'hFFFF, 1'b1, 1'b0);
        cycle(1'b1, 6'd63, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        cycle(1'b1, 6'd63, 1'b0, 16'h0,    1'b0, 1'b0);
        cycle(1'b1, 6'd0,  1'b0, 16'h0,    1'b0, 1'b1);
        check("flush_read_old", 32'(read_set_valid_out), 32'hFFFF);
        check("flush_read_rv",  32'(read_valid_out),     32'd1);
        low = ready_out ? 0 : 1;
        dones = 0;
        for (int i = 0; i < NS; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 6'd0 : 6'd63, (i % 3) != 0, 16'hFFFF, 1'b1, i == 10 || i == 40);
            if (!ready_out) low++;
            dones += int'(flush_done_out);
        end
        repeat (3) begin
            cycle(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0);
            dones += int'(flush_done_out);
        end
        check("flush_ready_low", 32'(low),   32'd64);
        check("flush_done_cnt",  32'(dones), 32'd1);
        cycle(1'b1, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("flush_set0", 32'(read_set_valid_out), 32'h0000);
        cycle(1'b1, 6'd63, 1'b0, 16'h0, 1'b0, 1'b0);
        check("flush_set63", 32'(read_set_valid_out), 32'h0000);

        for (int i = 0; i < 1500; i++) begin
            logic [5:0]  a;
            logic [15:0] mk_;
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       mk_ = 16'h0000;
                1:       mk_ = 16'hFFFF;
                default: mk_ = 16'($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)), mk_,
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
        end
        repeat (NS + 2) cycle(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Reset in the middle of a sweep.
        cycle(1'b1, 6'd5, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        cycle(1'b1, 6'd5, 1'b0, 16'h0,    1'b0, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 16'h0,    1'b0, 1'b1);
        repeat (20) cycle(1'b0, 6'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        reset_in = 1'b1;
        #1;
        check("rst_ready", 32'(ready_out),                  32'd0);
        check("rst_rv",    32'(read_valid_out),             32'd0);
        check("rst_set",   32'(read_set_valid_out),         32'd0);
        check("rst_all",   32'(read_all_valid_out),         32'd0);
        check("rst_first", 32'(read_first_invalid_way_out), 32'd0);
        check("rst_done",  32'(flush_done_out),             32'd0);
        model_reset();
        repeat (2) cycle(1'b1, 6'd5, 1'b0, 16'h0, 1'b0, 1'b0);
        reset_in = 1'b0;
        run_init("reinit");
        cycle(1'b1, 6'd5, 1'b0, 16'h0, 1'b0, 1'b0);
        check("reinit_set5", 32'(read_set_valid_out), 32'h0000);

        // 8-set, 3-way build.
        s_rst = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk_in);
            #1;
            n++;
            if (s_ready) break;
        end
        check("small_init_len", 32'(n),      32'd8);
        check("small_done",     32'(s_done), 32'd1);
        s_en = 1'b1; s_addr = 3'd2; s_we = 1'b1; s_mask = 3'b101; s_val = 1'b1;
        @(posedge clk_in);
        #1;
        s_we = 1'b0; s_mask = 3'b000;
        @(posedge clk_in);
        #1;
        s_en = 1'b0;
        check("small_rv",    32'(s_rv),    32'd1);
        check("small_set",   32'(s_set),   32'h5);
        check("small_first", 32'(s_first), 32'd1);
        check("small_all",   32'(s_all),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
